// File: rtl/instruction_queue.sv
// Prefetch queue of opcode/operand bytes between the data bus and the decoder.
// Bytes are captured on a phi2-qualified fetch strobe; the oldest byte is presented to the decoder.
module instruction_queue #(
  parameter int                DATA_W       = 8,
  parameter int                DEPTH        = 4,
  parameter logic [DATA_W-1:0] RESET_OPCODE = '0
) (
  input  logic                         fclk,
  input  logic                         reset,
  input  logic [DATA_W-1:0]            data_in,
  input  logic                         phi2,
  input  logic                         ir_signal,
  input  logic                         pop,
  input  logic                         flush,
  output logic [DATA_W-1:0]            instruction_decode_out,
  output logic                         opcode_valid,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] hold;

  logic             push_en;
  logic             pop_en;
  logic             push_acc;
  logic             overflow;
  logic             underflow;
  logic             mem_we;
  logic [PTR_W-1:0] mem_waddr;

  always_comb begin
    push_en   = ir_signal & phi2;
    pop_en    = pop & (count != '0);
    // A full queue still accepts a push when the head leaves in the same cycle.
    push_acc  = push_en & (~full | pop_en);
    overflow  = push_en & full & ~pop_en;
    underflow = pop & (count == '0);
    mem_we    = flush ? push_en : push_acc;
    mem_waddr = flush ? '0 : wr_ptr;
  end

  // Storage: no reset, contents are only meaningful below count.
  always_ff @(posedge fclk) begin
    if (mem_we) begin
      mem[mem_waddr] <= data_in;
    end
  end

  // Control state: pointers, occupancy, held head value and sticky error.
  always_ff @(posedge fclk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      error  <= 1'b0;
      hold   <= RESET_OPCODE;
    end else if (flush) begin
      // Branch: drop everything, optionally reloading the target byte into slot 0.
      rd_ptr <= '0;
      error  <= 1'b0;
      if (push_en) begin
        wr_ptr <= PTR_ONE;
        count  <= CNT_ONE;
      end else begin
        wr_ptr <= '0;
        count  <= '0;
      end
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        hold   <= mem[rd_ptr];
      end
      case ({push_acc, pop_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (overflow | underflow) begin
        error <= 1'b1;
      end
    end
  end

  always_comb begin
    opcode_valid           = (count != '0);
    full                   = (count == CNT_MAX);
    instruction_decode_out = opcode_valid ? mem[rd_ptr] : hold;
  end

endmodule

// File: tb/tb_instruction_queue.sv
// Randomised and directed scoreboard bench for instruction_queue against a byte-queue reference model.
module tb_instruction_queue;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH+1);
  localparam logic [DATA_W-1:0] RST_OP = 8'h00;

  logic              fclk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] data_in;
  logic              phi2, ir_signal, pop, flush;
  logic [DATA_W-1:0] instruction_decode_out;
  logic              opcode_valid, full, error;
  logic [CW-1:0]     count;

  instruction_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_OPCODE(RST_OP)) dut (
    .fclk(fclk), .reset(reset), .data_in(data_in), .phi2(phi2),
    .ir_signal(ir_signal), .pop(pop), .flush(flush),
    .instruction_decode_out(instruction_decode_out), .opcode_valid(opcode_valid),
    .full(full), .count(count), .error(error)
  );

  always #5 fclk = ~fclk;

  typedef struct packed {
    logic [DATA_W-1:0] out;
    logic              vld;
    logic              ful;
    logic [CW-1:0]     cnt;
    logic              err;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: a plain byte queue plus the last popped value and error flag.
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_hold;
  logic              m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    e.out = (m_q.size() != 0) ? m_q[0] : m_hold;
    e.vld = (m_q.size() != 0);
    e.ful = (m_q.size() == DEPTH);
    e.cnt = CW'(m_q.size());
    e.err = m_err;
    return e;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_hold = RST_OP;
    m_err  = 1'b0;
  endtask

  task automatic model_step(input logic ir, input logic ph, input logic p, input logic fl,
                            input logic [DATA_W-1:0] d);
    logic push;
    logic took;
    push = ir & ph;
    if (fl) begin
      m_q.delete();
      m_err = 1'b0;
      if (push) m_q.push_back(d);
    end else begin
      took = p && (m_q.size() != 0);
      if (p && m_q.size() == 0) m_err = 1'b1;
      if (push && m_q.size() == DEPTH && !took) m_err = 1'b1;
      if (took) m_hold = m_q.pop_front();
      if (push && m_q.size() < DEPTH) m_q.push_back(d);
    end
  endtask

  // One clock of stimulus: drive at negedge, record the expected post-edge state.
  task automatic step(input logic ir, input logic ph, input logic p, input logic fl,
                      input logic [DATA_W-1:0] d);
    @(negedge fclk);
    ir_signal = ir; phi2 = ph; pop = p; flush = fl; data_in = d;
    model_step(ir, ph, p, fl, d);
    exp_q.push_back(model_expect());
    @(posedge fclk);
  endtask

  task automatic push_b(input logic [DATA_W-1:0] d);
    step(1'b1, 1'b1, 1'b0, 1'b0, d);
  endtask

  task automatic pop_b();
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out"},   32'(instruction_decode_out), 32'(RST_OP));
    chk({tag, "_vld"},   32'(opcode_valid), 32'd0);
    chk({tag, "_full"},  32'(full), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_err"},   32'(error), 32'd0);
  endtask

  // Monitor: compares DUT outputs shortly after every active edge.
  always @(posedge fclk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("out",   32'(instruction_decode_out), 32'(e.out));
      chk("vld",   32'(opcode_valid), 32'(e.vld));
      chk("full",  32'(full), 32'(e.ful));
      chk("count", 32'(count), 32'(e.cnt));
      chk("err",   32'(error), 32'(e.err));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; data_in = '0; phi2 = 0; ir_signal = 0; pop = 0; flush = 0;
    model_reset();
    #1;
    check_reset_outputs("rst_init");
    repeat (2) @(negedge fclk);
    reset = 1'b0;

    step(0, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'hA9);

    push_b(8'hA9); push_b(8'h05); push_b(8'h8D); push_b(8'h00);
    repeat (4) pop_b();

    push_b(8'hA9); push_b(8'h05); push_b(8'h8D); push_b(8'h00);
    step(1, 1, 1, 0, 8'h4C);
    repeat (4) pop_b();

    push_b(8'h11); push_b(8'h22); push_b(8'h33); push_b(8'h44);
    push_b(8'hEA);
    repeat (4) pop_b();
    pop_b();
    step(0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 1, 8'h00);

    push_b(8'h31); push_b(8'h32); push_b(8'h33);
    step(1, 1, 1, 1, 8'h20);
    pop_b();
    push_b(8'h41); push_b(8'h42);
    step(0, 0, 1, 1, 8'h00);

    // Asynchronous reset in the middle of a burst.
    push_b(8'h51); push_b(8'h52);
    @(negedge fclk);
    ir_signal = 0; phi2 = 0; pop = 0; flush = 0;
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    model_reset();
    repeat (2) @(negedge fclk);
    reset = 1'b0;
    push_b(8'h60);
    pop_b();

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 80),
           ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 5),
           DATA_W'($urandom));
    end
    step(0, 0, 0, 0, 8'h00);

    repeat (3) @(negedge fclk);
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_queue.md
Name: instruction_queue

Overview:
- Parametrised successor to the single-byte instruction latch: a synchronous prefetch queue of opcode/operand bytes between the data bus and the decoder.
- Captures bus bytes on a fetch strobe qualified by phi2 and presents the oldest byte to the decoder.
- Supports pop, branch flush with same-cycle reload, occupancy status and a sticky error flag.
- Fully clocked on fclk; the level-sensitive latch behaviour is replaced by flops.

Parameters:
- DATA_W, 8, width of each queued byte/word.
- DEPTH, 4, number of entries; power of two, >= 2.
- RESET_OPCODE, 8'h00 (DATA_W bits), value of instruction_decode_out after reset while the queue is empty.

Ports:
- fclk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  DATA_W  byte from the data bus.
- phi2  input  1  bus phase qualifier; a push is accepted only when phi2=1.
- ir_signal  input  1  push request from the decoder/fetch control.
- pop  input  1  decoder consumed the head entry.
- flush  input  1  discard all entries (branch/interrupt).
- instruction_decode_out  output  DATA_W  head entry, or held value when empty.
- opcode_valid  output  1  queue not empty.
- full  output  1  count == DEPTH.
- count  output  $clog2(DEPTH+1)  number of valid entries.
- error  output  1  sticky overflow/underflow flag.

Behaviour:
- Reset (async, asserted): wr_ptr=rd_ptr=0, count=0, error=0, hold=RESET_OPCODE.
  - Outputs during reset: instruction_decode_out=RESET_OPCODE, opcode_valid=0, full=0, count=0, error=0.
  - Storage array contents are don't-care.
- push_en = ir_signal & phi2. pop_en = pop & (count != 0).
- instruction_decode_out = mem[rd_ptr] when count != 0; otherwise = hold.
  - hold loads mem[rd_ptr] on every accepted pop; it is unchanged by flush.
- Latency: a byte pushed at edge N appears at instruction_decode_out after edge N if it becomes head; no combinational data_in -> out path.
- Normal cycle (flush=0):
  - push_en & !full: mem[wr_ptr]<=data_in, wr_ptr++.
  - push_en & full & pop_en: accepted; count unchanged.
  - push_en & full & !pop: byte dropped, error<=1.
  - pop_en: rd_ptr++. pop while count==0: ignored, error<=1.
  - count += accepted push - accepted pop.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Flush cycle (flush=1, highest priority):
  - rd_ptr<=0, wr_ptr<=0, count<=0, error<=0; pop ignored (no underflow flagged).
  - If push_en in the same cycle: mem[0]<=data_in, wr_ptr<=1, count<=1 (flush-and-load of the branch target byte).
- full and opcode_valid are decoded from the registered count.
- error is cleared only by reset or flush.
- Reset asserted mid-operation overrides everything immediately; the first push after deassertion lands in mem[0].

Test Plan:
- Reset then idle -> out=8'h00, opcode_valid=0, count=0, error=0; push A9 with phi2=0 -> ignored, count stays 0.
- Push A9, 05, 8D, 00 (phi2=1) -> count 1,2,3,4, full=1 after 4th, out=A9; pop x4 -> out 05, 8D, 00, then 00 held with opcode_valid=0.
- Full queue, push 4C with pop same cycle -> count stays 4, error=0; later pops return 05, 8D, 00, 4C (wrap across pointer 3->0).
- Full queue, push EA without pop -> EA dropped, count=4, error=1; pop on empty queue -> error stays 1 until flush.
- 3 entries queued, flush with push 20 same cycle -> count=1, out=20, error=0; flush alone -> count=0, out=last popped value.
- Assert reset while count=2 mid-burst -> all outputs return to reset values immediately; next push 60 -> out=60, count=1.
